neopixel_frame_sequencer: RTL and testbench

//  Autonomous frame generator for the neopixel block: each frame tick it writes C_PIXELS colour words

---
 rtl/neopixel_pkg.sv | 67 ++++++
 rtl/neopixel_seq_tick.sv | 31 +++
 rtl/neopixel_frame_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_neopixel_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared definitions for the neopixel frame sequencer.
//   - seq_state_e : sequencer FSM state encoding
//   - rgb_t       : one pixel colour, packed {G,R,B} as the neopixel expects
//   - CTRL_START  : control-register write value that starts transmission
//   - wheel()     : 8-bit hue to colour-wheel RGB
//   - scale_rgb() : per-channel brightness scaling, c' = (c*(br+1))>>8
package neopixel_pkg;

    localparam logic [31:0] CTRL_START = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_KICK,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } rgb_t;

    // Three 85-step segments; each has one channel rising, one falling, one off.
    function automatic rgb_t wheel(input logic [7:0] h);
        logic [7:0] k, up, dn;
        rgb_t c;
        c = '0;
        if (h < 8'd85) begin
            k = h;
        end else if (h < 8'd170) begin
            k = h - 8'd85;
        end else begin
            k = h - 8'd170;
        end
        up = 8'(k * 8'd3);
        dn = 8'd255 - up;
        if (h < 8'd85) begin
            c.r = dn;
            c.g = up;
        end else if (h < 8'd170) begin
            c.g = dn;
            c.b = up;
        end else begin
            c.r = up;
            c.b = dn;
        end
        return c;
    endfunction

    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] prod;
        prod = 16'(c) * (16'(br) + 16'd1);
        return 8'(prod >> 8);
    endfunction

    function automatic rgb_t scale_rgb(input rgb_t c, input logic [7:0] br);
        rgb_t s;
        s.g = scale_chan(c.g, br);
        s.r = scale_chan(c.r, br);
        s.b = scale_chan(c.b, br);
        return s;
    endfunction

endpackage

// File: rtl/neopixel_seq_tick.sv
// Frame-tick divider: free-running counter that wraps at C_PERIOD-1 and
// emits a registered one-cycle tick on each wrap.
// Ports:
//   clock   in  system clock
//   reset_n in  synchronous active-low reset (counter and tick cleared)
//   tick    out one-cycle pulse every C_PERIOD cycles
module neopixel_seq_tick #(
    parameter int unsigned C_PERIOD = 2083333
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CNT_W = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(C_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Counter and tick pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Autonomous frame generator driving the neopixel control interface.
// Each enabled frame tick it writes C_PIXELS colour words (rainbow or solid,
// brightness scaled), writes the start bit to the control register, waits for
// transmission to finish and pulses frame_done.
// Optional build macro NEOPIXEL_SEQ_POLL_EN: wait by polling the control
// register busy bit instead of a fixed C_WAIT_CYCLES delay.
// Ports:
//   clock, reset_n   in   clock, synchronous active-low reset
//   enable           in   run frames (sampled at the frame tick)
//   mode             in   0 rainbow, 1 solid (sampled at frame start)
//   solid_color      in   {G,R,B} for solid mode (sampled at frame start)
//   brightness       in   global scale (sampled at frame start)
//   busy             out  frame in progress
//   frame_done       out  one-cycle pulse at frame completion
//   clock_ctrl       out  clock pass-through
//   reset_ctrl       out  registered ~reset_n
//   write_readf      out  1 = write cycle
//   address          out  register address
//   write_data       out  write data
//   read_data        in   read data, one cycle after a read address
module neopixel_frame_sequencer
    import neopixel_pkg::*;
#(
    parameter int unsigned C_PIXELS      = 12,
    parameter int unsigned C_FREQ_HZ     = 125000000,
    parameter int unsigned C_FRAME_HZ    = 60,
    parameter logic [7:0]  C_HUE_STEP    = 8'd21,
    parameter logic [31:0] C_CTRL_ADDR   = 32'h100,
    parameter int unsigned C_WAIT_CYCLES = 51250
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        mode,
    input  logic [23:0] solid_color,
    input  logic [7:0]  brightness,
    output logic        busy,
    output logic        frame_done,
    output logic        clock_ctrl,
    output logic        reset_ctrl,
    output logic        write_readf,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    localparam int unsigned TICK_PERIOD = C_FREQ_HZ / C_FRAME_HZ;
    localparam int unsigned PIX_W       = $clog2(C_PIXELS + 1);
    localparam int unsigned WAIT_W      = (C_WAIT_CYCLES < 4) ? 2 : $clog2(C_WAIT_CYCLES);
    localparam logic [PIX_W-1:0] PIX_END = PIX_W'(C_PIXELS);

    seq_state_e       state, state_nx;
    logic [PIX_W-1:0] pix, pix_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic [7:0]       phase, phase_nx;
    logic             busy_nx, frame_done_nx, write_readf_nx;
    logic [31:0]      address_nx, write_data_nx;
    logic             latch;
    logic             lat_mode;
    rgb_t             lat_color;
    logic [7:0]       lat_bright;
    logic             tick;
    logic [7:0]       hue;
    rgb_t             base_color, scaled_color;
    logic [31:0]      pixel_word;

    neopixel_seq_tick #(
        .C_PERIOD (TICK_PERIOD)
    ) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign clock_ctrl = clock;

    always_ff @(posedge clock) begin
        reset_ctrl <= ~reset_n;
    end

    // Colour word for the pixel currently being issued.
    always_comb begin
        hue          = phase + 8'(8'(pix) * C_HUE_STEP);
        base_color   = lat_mode ? lat_color : wheel(hue);
        scaled_color = scale_rgb(base_color, lat_bright);
        pixel_word   = {8'h00, scaled_color};
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pix         <= '0;
            wait_cnt    <= '0;
            phase       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            write_readf <= 1'b0;
            address     <= '0;
            write_data  <= '0;
            lat_mode    <= 1'b0;
            lat_color   <= '0;
            lat_bright  <= '0;
        end else begin
            state       <= state_nx;
            pix         <= pix_nx;
            wait_cnt    <= wait_nx;
            phase       <= phase_nx;
            busy        <= busy_nx;
            frame_done  <= frame_done_nx;
            write_readf <= write_readf_nx;
            address     <= address_nx;
            write_data  <= write_data_nx;
            if (latch) begin
                lat_mode   <= mode;
                lat_color  <= rgb_t'(solid_color);
                lat_bright <= brightness;
            end
        end
    end

`ifdef NEOPIXEL_SEQ_POLL_EN
    logic read_hi_unused;
    assign read_hi_unused = ^read_data[31:1];
`else
    logic read_unused;
    assign read_unused = ^read_data;
`endif

    // Next state; bus outputs are computed one cycle ahead so the bus
    // content always matches the state it is shown in.
    always_comb begin
        state_nx       = state;
        pix_nx         = pix;
        wait_nx        = wait_cnt;
        phase_nx       = phase;
        busy_nx        = busy;
        frame_done_nx  = 1'b0;
        write_readf_nx = 1'b0;
        address_nx     = address;
        write_data_nx  = write_data;
        latch          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tick && enable) begin
                    state_nx = ST_LOAD;
                    busy_nx  = 1'b1;
                    pix_nx   = '0;
                    latch    = 1'b1;
                end
            end
            ST_LOAD, ST_WRITE: begin
                write_readf_nx = 1'b1;
                if (pix == PIX_END) begin
                    state_nx      = ST_KICK;
                    address_nx    = C_CTRL_ADDR;
                    write_data_nx = CTRL_START;
                end else begin
                    state_nx      = ST_WRITE;
                    address_nx    = 32'(pix);
                    write_data_nx = pixel_word;
                    pix_nx        = pix + PIX_W'(1);
                end
            end
            ST_KICK: begin
                state_nx = ST_WAIT;
                wait_nx  = WAIT_W'(1);
            end
            ST_WAIT: begin
`ifdef NEOPIXEL_SEQ_POLL_EN
                // wait_cnt = cycles since the kick; the first busy read
                // response arrives two cycles after it.
                address_nx = C_CTRL_ADDR;
                if (wait_cnt < WAIT_W'(2)) begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
                if ((wait_cnt >= WAIT_W'(2)) && !read_data[0]) begin
                    state_nx      = ST_DONE;
                    frame_done_nx = 1'b1;
                    busy_nx       = 1'b0;
                    phase_nx      = phase + 8'd1;
                end
`else
                // frame_done lands C_WAIT_CYCLES cycles after the kick write.
                if (wait_cnt >= WAIT_W'(C_WAIT_CYCLES - 1)) begin
                    state_nx      = ST_DONE;
                    frame_done_nx = 1'b1;
                    busy_nx       = 1'b0;
                    phase_nx      = phase + 8'd1;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Scoreboard bench for neopixel_frame_sequencer (4 pixels, tick every 10
// cycles, 5-cycle post-kick wait). A frame-level reference model pushes the
// expected bus writes and frame_done events with cycle stamps; a monitor pops
// and compares whenever the DUT drives a write or frame_done.
module tb_neopixel_frame_sequencer;

    localparam int P      = 4;
    localparam int PERIOD = 1000 / 100;
    localparam int W      = 5;
    localparam int HOLD   = 7;
    localparam int HUE    = 21;
    localparam logic [31:0] CTRL = 32'h100;
`ifdef NEOPIXEL_SEQ_POLL_EN
    localparam int DONE_LAT = HOLD + 2;
`else
    localparam int DONE_LAT = W;
`endif

    logic        clock = 1'b0;
    logic        reset_n, enable, mode;
    logic [23:0] solid_color;
    logic [7:0]  brightness;
    logic        busy, frame_done, clock_ctrl, reset_ctrl, write_readf;
    logic [31:0] address, write_data;
    logic [31:0] read_data = '0;

    neopixel_frame_sequencer #(
        .C_PIXELS      (P),
        .C_FREQ_HZ     (1000),
        .C_FRAME_HZ    (100),
        .C_HUE_STEP    (8'd21),
        .C_CTRL_ADDR   (CTRL),
        .C_WAIT_CYCLES (W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .mode        (mode),
        .solid_color (solid_color),
        .brightness  (brightness),
        .busy        (busy),
        .frame_done  (frame_done),
        .clock_ctrl  (clock_ctrl),
        .reset_ctrl  (reset_ctrl),
        .write_readf (write_readf),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   in_rst = 1'b1;
    int   phase = 0;
    int   free_at = 0;
    int   busy_from = 1;
    int   busy_to = 0;
    int   kick_seen = -1000;

    // Cycle index since reset release; in_rst marks cycles after a reset edge.
    always @(posedge clock) begin
        in_rst <= !reset_n;
        cyc    <= reset_n ? cyc + 1 : 0;
    end

    function automatic int chan_scale(int c, int br);
        return (c * (br + 1)) / 256;
    endfunction

    function automatic logic [31:0] pixel_word(int ph, int px, bit md, logic [23:0] col, int br);
        int h, k, r, g, b;
        if (md) begin
            g = int'(col[23:16]);
            r = int'(col[15:8]);
            b = int'(col[7:0]);
        end else begin
            h = (ph + px * HUE) % 256;
            if (h < 85) begin
                r = 255 - 3 * h; g = 3 * h; b = 0;
            end else if (h < 170) begin
                k = h - 85; r = 0; g = 255 - 3 * k; b = 3 * k;
            end else begin
                k = h - 170; r = 3 * k; g = 0; b = 255 - 3 * k;
            end
        end
        r = chan_scale(r, br);
        g = chan_scale(g, br);
        b = chan_scale(b, br);
        return {8'h00, 8'(g), 8'(r), 8'(b)};
    endfunction

    // Reference model: decides frame starts and pushes expected transactions.
    always @(negedge clock) begin
        if (in_rst) begin
            expq.delete();
            phase = 0; free_at = 0; busy_from = 1; busy_to = 0;
        end else if (reset_n && (cyc % PERIOD == 0) && cyc != 0 && enable && cyc >= free_at) begin
            int kick;
            exp_t e;
            for (int i = 0; i < P; i++) begin
                e.cyc = cyc + 2 + i; e.is_done = 1'b0; e.addr = 32'(i);
                e.data = pixel_word(phase, i, mode, solid_color, int'(brightness));
                expq.push_back(e);
            end
            kick = cyc + 2 + P;
            e.cyc = kick; e.is_done = 1'b0; e.addr = CTRL; e.data = 32'h1;
            expq.push_back(e);
            e.cyc = kick + DONE_LAT; e.is_done = 1'b1; e.addr = '0; e.data = '0;
            expq.push_back(e);
            busy_from = cyc + 1;
            busy_to   = kick + DONE_LAT - 1;
            free_at   = kick + DONE_LAT + 1;
            phase     = (phase + 1) % 256;
        end
    end

    // Monitor: compare DUT outputs against the scoreboard.
    always @(negedge clock) begin
        if (in_rst) begin
            vectors++;
            if (write_readf !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || reset_ctrl !== 1'b1 ||
                address !== 32'h0 || write_data !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_values: we=%b busy=%b done=%b rctl=%b addr=%h data=%h, need 0 0 0 1 0 0",
                         write_readf, busy, frame_done, reset_ctrl, address, write_data);
            end
        end else begin
            vectors++;
            if (busy !== (cyc >= busy_from && cyc <= busy_to) || reset_ctrl !== 1'b0 || clock_ctrl !== 1'b0) begin
                miscompares++;
                $display("FAIL status cyc=%0d: busy=%b rctl=%b cctl=%b, need busy=%b rctl=0 cctl=0",
                         cyc, busy, reset_ctrl, clock_ctrl, (cyc >= busy_from && cyc <= busy_to));
            end
            if (write_readf === 1'b1 || frame_done === 1'b1) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output cyc=%0d: we=%b done=%b addr=%h data=%h, none expected",
                             cyc, write_readf, frame_done, address, write_data);
                end else begin
                    mon_e = expq.pop_front();
                    if (mon_e.cyc != cyc || frame_done !== mon_e.is_done || write_readf !== !mon_e.is_done ||
                        (!mon_e.is_done && (address !== mon_e.addr || write_data !== mon_e.data))) begin
                        miscompares++;
                        $display("FAIL transaction: got cyc=%0d we=%b done=%b addr=%h data=%h, need cyc=%0d done=%b addr=%h data=%h",
                                 cyc, write_readf, frame_done, address, write_data,
                                 mon_e.cyc, mon_e.is_done, mon_e.addr, mon_e.data);
                    end
                end
            end else if (expq.size() != 0 && expq[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                mon_e = expq.pop_front();
                $display("FAIL missing_output: nothing seen by cyc=%0d, need done=%b addr=%h data=%h at cyc=%0d",
                         cyc, mon_e.is_done, mon_e.addr, mon_e.data, mon_e.cyc);
            end
        end
    end

    // Slave side of read_data: busy for HOLD cycles after a kick when polling,
    // random noise otherwise.
    always @(negedge clock) begin
        if (in_rst) kick_seen = -1000;
        else if (write_readf === 1'b1 && address === CTRL) kick_seen = cyc;
    end

    always @(posedge clock) begin
        #1;
`ifdef NEOPIXEL_SEQ_POLL_EN
        read_data = {31'($urandom()), ((cyc - kick_seen) >= 1 && (cyc - kick_seen) <= HOLD)};
`else
        read_data = $urandom();
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_frame_offset(input int off, input string tag);
        int n;
        n = 0;
        while (cyc != busy_from + off && n < 200) begin
            step(1);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no frame within 200 cycles, need one", tag);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode = 1'b0;
        solid_color = 24'h0; brightness = 8'd255;
        step(3);
        reset_n = 1'b1;

        // Rainbow at full brightness, then solid at half.
        enable = 1'b1;
        step(20);
        mode = 1'b1; solid_color = 24'h102030; brightness = 8'd127;
        step(25);

        // Drop enable while pixels are being written.
        wait_frame_offset(2, "enable_drop");
        enable = 1'b0;
        step(40);

        // Continuous run long enough for the phase to wrap.
        mode = 1'b0; brightness = 8'd200; enable = 1'b1;
        step(PERIOD * 2 * 260);

        // Random settings and enable toggling.
        repeat (3000) begin
            step(1);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 31) == 0) mode = 1'($urandom());
            if ($urandom_range(0, 15) == 0) solid_color = 24'($urandom());
            if ($urandom_range(0, 15) == 0) brightness = 8'($urandom());
        end

        // Reset in the middle of a frame.
        enable = 1'b1;
        wait_frame_offset(3, "mid_reset");
        reset_n = 1'b0; enable = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(30);
        mode = 1'b0; brightness = 8'd255; enable = 1'b1;
        step(40);

        enable = 1'b0;
        step(40);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected outputs never seen, need 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
